// File: rtl/blk_mem_pkg.sv
// Purpose : shared constants and types for the parametrised single-port block RAM.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: WriteMode encodings (WM_*) and the clear-sequencer state type.
package blk_mem_pkg;

  localparam int WM_WRITE_FIRST = 0;
  localparam int WM_READ_FIRST  = 1;
  localparam int WM_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    DONE  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/blk_mem_init_seq.sv
// Purpose : post-reset clear sequencer; walks every address once, then parks in DONE.
// Latency : init_busy stays high for exactly 2**AddrWidth clocks after reset release.
// Backpressure: none; while busy the sequencer owns the array and user accesses are dropped.
// Ports:
//   clka, rsta_n        clock and asynchronous active-low reset
//   clr_we, clr_addr    array write strobe and address for the fill word
//   init_busy           high while the sequencer owns the array
module blk_mem_init_seq
  import blk_mem_pkg::*;
#(
  parameter int AddrWidth = 12
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  output logic                 clr_we,
  output logic [AddrWidth-1:0] clr_addr,
  output logic                 init_busy
);

  clr_state_e           state_q, state_d;
  logic [AddrWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      // Last address written on this edge; the counter wraps to 0 harmlessly.
      if (cnt_q == {AddrWidth{1'b1}}) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = cnt_q;
  assign init_busy = (state_q == CLEAR);

endmodule

// File: rtl/blk_mem_sp_param.sv
// Purpose : behavioural single-port BRAM with byte-lane writes, selectable write mode, output register.
// Latency : douta 1 clock after an accepted access, Regdouta 1 further clock (when regcea=1).
// Backpressure: none; accesses during init_busy or with ena=0 are dropped, not queued.
// Ports:
//   clka, rsta_n         clock and asynchronous active-low reset (clears douta/Regdouta)
//   ena, wea, addra,dina user port; wea has one bit per ByteWidth lane
//   regcea               clock enable of the output register
//   douta, Regdouta      array latch and pipeline register outputs
//   init_busy            clear sequencer active (tied 0 when not compiled in)
// Config  : define BLK_MEM_SP_PARAM_INIT_CLEAR_EN to fill the array with InitValue after every reset.
module blk_mem_sp_param
  import blk_mem_pkg::*;
#(
  parameter int                   AddrWidth = 12,
  parameter int                   DataWidth = 9,
  parameter int                   ByteWidth = 9,
  parameter int                   WriteMode = WM_WRITE_FIRST,
  parameter logic [DataWidth-1:0] InitValue = '0,
  localparam int                  NumBytes  = DataWidth / ByteWidth,
  localparam int                  Depth     = 2 ** AddrWidth
) (
  input  logic                 clka,
  input  logic                 rsta_n,
  input  logic                 ena,
  input  logic                 regcea,
  input  logic [NumBytes-1:0]  wea,
  input  logic [AddrWidth-1:0] addra,
  input  logic [DataWidth-1:0] dina,
  output logic [DataWidth-1:0] douta,
  output logic [DataWidth-1:0] Regdouta,
  output logic                 init_busy
);

  if (WriteMode != WM_WRITE_FIRST && WriteMode != WM_READ_FIRST &&
      WriteMode != WM_NO_CHANGE) begin : g_bad_mode
    $error("blk_mem_sp_param: illegal WriteMode %0d", WriteMode);
  end
  if (ByteWidth <= 0 || (DataWidth % ByteWidth) != 0) begin : g_bad_width
    $error("blk_mem_sp_param: DataWidth %0d not a multiple of ByteWidth %0d",
           DataWidth, ByteWidth);
  end

  logic [DataWidth-1:0] mem [Depth];

  logic                 accept;
  logic                 mem_we;
  logic [NumBytes-1:0]  mem_lane_we;
  logic [AddrWidth-1:0] mem_addr;
  logic [DataWidth-1:0] mem_wdat;
  logic [DataWidth-1:0] rd_word;
  logic [DataWidth-1:0] merged_word;
  logic [DataWidth-1:0] douta_q, douta_d;
  logic [DataWidth-1:0] regdouta_q;

`ifdef BLK_MEM_SP_PARAM_INIT_CLEAR_EN
  logic                 clr_we;
  logic [AddrWidth-1:0] clr_addr;

  blk_mem_init_seq #(
    .AddrWidth (AddrWidth)
  ) u_init_seq (
    .clka      (clka),
    .rsta_n    (rsta_n),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .init_busy (init_busy)
  );

  assign accept      = ena & ~init_busy;
  // The sequencer takes the whole write port while it runs.
  assign mem_we      = clr_we | (accept & (|wea));
  assign mem_lane_we = clr_we ? {NumBytes{1'b1}} : wea;
  assign mem_addr    = clr_we ? clr_addr : addra;
  assign mem_wdat    = clr_we ? InitValue : dina;
`else
  if ($bits(InitValue) != DataWidth) begin : g_bad_init
    $error("blk_mem_sp_param: InitValue width mismatch");
  end

  assign init_busy   = 1'b0;
  assign accept      = ena;
  assign mem_we      = accept & (|wea);
  assign mem_lane_we = wea;
  assign mem_addr    = addra;
  assign mem_wdat    = dina;
`endif

  assign rd_word = mem[addra];

  // Word as it will look after this write: new lanes where enabled, old elsewhere.
  always_comb begin
    merged_word = rd_word;
    for (int i = 0; i < NumBytes; i++) begin
      if (wea[i]) begin
        merged_word[i*ByteWidth +: ByteWidth] = dina[i*ByteWidth +: ByteWidth];
      end
    end
  end

  always_comb begin
    douta_d = douta_q;
    if (accept) begin
      if (wea == '0) begin
        douta_d = rd_word;
      end else if (WriteMode == WM_WRITE_FIRST) begin
        douta_d = merged_word;
      end else if (WriteMode == WM_READ_FIRST) begin
        douta_d = rd_word;
      end
      // NO_CHANGE with a write: douta holds.
    end
  end

  // The array has no reset of its own; gating on rsta_n drops a write that
  // coincides with reset assertion while keeping the contents otherwise intact.
  always_ff @(posedge clka) begin
    if (rsta_n && mem_we) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (mem_lane_we[i]) begin
          mem[mem_addr][i*ByteWidth +: ByteWidth] <= mem_wdat[i*ByteWidth +: ByteWidth];
        end
      end
    end
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      douta_q    <= '0;
      regdouta_q <= '0;
    end else begin
      douta_q <= douta_d;
      if (regcea) begin
        regdouta_q <= douta_q;
      end
    end
  end

  assign douta    = douta_q;
  assign Regdouta = regdouta_q;

endmodule

// File: tb/tb_blk_mem_sp_param.sv
// Purpose : directed self-checking bench; one instance per write mode, shared stimulus.
// Latency : checks douta one edge and Regdouta two edges after each access.
// Backpressure: n/a.
module tb_blk_mem_sp_param;

  localparam int AW = 4;
  localparam int DW = 18;
  localparam int BW = 9;
  localparam logic [DW-1:0] INIT = 18'h2A5A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          regcea;
  logic [1:0]    wea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;

  logic [DW-1:0] dout_wf, reg_wf, dout_rf, reg_rf, dout_nc, reg_nc;
  logic          busy_wf, busy_rf, busy_nc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blk_mem_sp_param #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(BW), .WriteMode(0), .InitValue(INIT))
    u_wf (.clka(clk), .rsta_n(rst_n), .ena(ena), .regcea(regcea), .wea(wea), .addra(addra),
          .dina(dina), .douta(dout_wf), .Regdouta(reg_wf), .init_busy(busy_wf));
  blk_mem_sp_param #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(BW), .WriteMode(1), .InitValue(INIT))
    u_rf (.clka(clk), .rsta_n(rst_n), .ena(ena), .regcea(regcea), .wea(wea), .addra(addra),
          .dina(dina), .douta(dout_rf), .Regdouta(reg_rf), .init_busy(busy_rf));
  blk_mem_sp_param #(.AddrWidth(AW), .DataWidth(DW), .ByteWidth(BW), .WriteMode(2), .InitValue(INIT))
    u_nc (.clka(clk), .rsta_n(rst_n), .ena(ena), .regcea(regcea), .wea(wea), .addra(addra),
          .dina(dina), .douta(dout_nc), .Regdouta(reg_nc), .init_busy(busy_nc));

  task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply one access, then sample 1 time unit after the edge.
  task automatic cyc(input logic en, input logic [1:0] we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    ena = en; wea = we; addra = a; dina = d;
    @(posedge clk); #1;
  endtask

`ifdef BLK_MEM_SP_PARAM_INIT_CLEAR_EN
  // Counts edges while busy; user writes of all-ones are attempted throughout.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    ena = 1'b1; wea = 2'b11; dina = 18'h3FFFF;
    while (busy_wf && n < 100) begin
      addra = n[AW-1:0];
      @(posedge clk); #1;
      n++;
    end
    check_val(tag, DW'(n), DW'(16));
    check_val({tag, "_rf"}, {17'd0, busy_rf}, 18'd0);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; regcea = 1'b1; wea = 2'b00; addra = '0; dina = '0;
    #2;
    check_val("rst_douta", dout_wf, 18'h0);
    check_val("rst_regdouta", reg_nc, 18'h0);
`ifdef BLK_MEM_SP_PARAM_INIT_CLEAR_EN
    check_val("rst_busy", {17'd0, busy_wf}, 18'd1);
`else
    check_val("rst_busy", {17'd0, busy_wf}, 18'd0);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

`ifdef BLK_MEM_SP_PARAM_INIT_CLEAR_EN
    count_busy("clr_busy_cycles");
    for (int a = 0; a < 16; a++) begin
      cyc(1'b1, 2'b00, a[AW-1:0], 18'h0);
      check_val($sformatf("clr_rd%0d", a), dout_wf, INIT);
    end
`endif

    // Byte lanes, WRITE_FIRST.
    cyc(1'b1, 2'b11, 4'd3, 18'h3FFFF);
    check_val("wf_full_wr", dout_wf, 18'h3FFFF);
    cyc(1'b1, 2'b01, 4'd3, 18'h00000);
    check_val("wf_lane_douta", dout_wf, 18'h3FE00);
    cyc(1'b0, 2'b00, 4'd0, 18'h0);
    check_val("wf_lane_regdouta", reg_wf, 18'h3FE00);

    // READ_FIRST.
    cyc(1'b1, 2'b11, 4'd5, 18'h12345);
    cyc(1'b1, 2'b11, 4'd5, 18'h00ABC);
    check_val("rf_old_word", dout_rf, 18'h12345);
    check_val("wf_new_word", dout_wf, 18'h00ABC);
    cyc(1'b1, 2'b00, 4'd5, 18'h0);
    check_val("rf_readback", dout_rf, 18'h00ABC);
    check_val("nc_readback", dout_nc, 18'h00ABC);

    // NO_CHANGE.
    cyc(1'b1, 2'b11, 4'd9, 18'h00111);
    cyc(1'b1, 2'b00, 4'd9, 18'h0);
    check_val("nc_prior_read", dout_nc, 18'h00111);
    cyc(1'b1, 2'b11, 4'd7, 18'h2AAAA);
    check_val("nc_hold_on_wr", dout_nc, 18'h00111);
    cyc(1'b1, 2'b00, 4'd7, 18'h0);
    check_val("nc_read7", dout_nc, 18'h2AAAA);

    // Back-to-back write then read.
    cyc(1'b1, 2'b11, 4'd10, 18'h0BEEF);
    cyc(1'b1, 2'b00, 4'd10, 18'h0);
    check_val("b2b_rf", dout_rf, 18'h0BEEF);

    // ena=0: nothing changes.
    cyc(1'b0, 2'b11, 4'd7, 18'h00000);
    cyc(1'b0, 2'b10, 4'd10, 18'h3FFFF);
    check_val("ena0_douta_nc", dout_nc, 18'h0BEEF);
    check_val("ena0_douta_wf", dout_wf, 18'h0BEEF);
    cyc(1'b1, 2'b00, 4'd7, 18'h0);
    check_val("ena0_arr7", dout_wf, 18'h2AAAA);
    cyc(1'b0, 2'b00, 4'd0, 18'h0);
    check_val("reg_follow", reg_wf, 18'h2AAAA);

    // regcea=0: Regdouta holds, douta updates.
    regcea = 1'b0;
    cyc(1'b1, 2'b00, 4'd10, 18'h0);
    check_val("regcea0_douta", dout_wf, 18'h0BEEF);
    check_val("regcea0_hold", reg_wf, 18'h2AAAA);
    cyc(1'b0, 2'b00, 4'd0, 18'h0);
    check_val("regcea0_hold2", reg_rf, 18'h2AAAA);
    regcea = 1'b1;
    cyc(1'b0, 2'b00, 4'd0, 18'h0);
    check_val("regcea1_load", reg_rf, 18'h0BEEF);

    // Async reset during a write: outputs clear without an edge, write is dropped.
    ena = 1'b1; wea = 2'b11; addra = 4'd10; dina = 18'h00001;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_douta", dout_wf, 18'h0);
    check_val("arst_regdouta", reg_rf, 18'h0);
    @(posedge clk); #1;
    ena = 1'b0; wea = 2'b00;
    rst_n = 1'b1;
`ifdef BLK_MEM_SP_PARAM_INIT_CLEAR_EN
    count_busy("rerelease_busy");
    cyc(1'b1, 2'b00, 4'd10, 18'h0);
    check_val("arst_recleared", dout_wf, INIT);
    // Reset mid-clear at counter 6.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int k = 0; k < 6; k++) cyc(1'b1, 2'b11, 4'd0, 18'h3FFFF);
    rst_n = 1'b0;
    #1;
    check_val("midclr_douta", dout_wf, 18'h0);
    check_val("midclr_busy", {17'd0, busy_wf}, 18'd1);
    rst_n = 1'b1;
    count_busy("midclr_busy_cycles");
`else
    cyc(1'b1, 2'b00, 4'd10, 18'h0);
    check_val("arst_wr_dropped", dout_wf, 18'h0BEEF);
    cyc(1'b1, 2'b00, 4'd7, 18'h0);
    check_val("arst_arr_kept", dout_rf, 18'h2AAAA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
